ifetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly downstream of the program counter block.
- Presents the current pc to the instruction cache and waits for ihit.
- Delivers the fetched word, with its pc and npc, into the IF/ID pipeline register.
- Tells the program counter when to advance (PCen) and what to load (cpc); handles decode stalls, branch/jump redirects and halt.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/ifetch_if.sv | 36 +++
 rtl/ifetch_hold_buf.sv | 39 +++
 rtl/ifetch_unit.sv | 173 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, fetch FSM states and the IF/ID entry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } ifetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

endpackage

// File: rtl/ifetch_if.sv
// Bundle of the fetch stage's PC, I-cache, decode and control signals.
interface ifetch_if;
  import cpu_types_pkg::*;

  // Handshakes: iREN=1 presents iaddr; ihit=1 in that same cycle returns iload
  // and the request completes (ihit with iREN=0 means nothing). dstall=1 means
  // decode refuses a new IF/ID entry at the next edge; PCen=1 loads cpc into the PC.
  word_t         pc;
  word_t         npc;
  logic          PCen;
  word_t         cpc;
  logic          iREN;
  word_t         iaddr;
  logic          ihit;
  word_t         iload;
  logic          dstall;
  logic          redirect;
  word_t         redirect_pc;
  logic          halt;
  logic          ifid_valid;
  word_t         ifid_instr;
  word_t         ifid_pc;
  word_t         ifid_npc;
  ifetch_state_t state;

  modport ifm (
    input  pc, npc, ihit, iload, dstall, redirect, redirect_pc, halt,
    output PCen, cpc, iREN, iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, state
  );

  modport tb (
    output pc, npc, ihit, iload, dstall, redirect, redirect_pc, halt,
    input  PCen, cpc, iREN, iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, state
  );

endinterface

// File: rtl/ifetch_hold_buf.sv
// Single-entry parking slot for a fetched word that decode could not accept yet.
module ifetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  drain,
  input  logic  clr,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t hold_q, hold_d;

  // Clear wins over load so a same-cycle redirect never leaves a stale entry.
  always_comb begin
    hold_d = hold_q;
    if (clr) begin
      hold_d.valid = 1'b0;
    end else if (load) begin
      hold_d       = d;
      hold_d.valid = 1'b1;
    end else if (drain) begin
      hold_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign q = hold_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: drives the I-cache, fills IF/ID and steers the PC.
// Define IFETCH_PERF_EN to add saturating fetch/stall/flush counters.
module ifetch_unit
  import cpu_types_pkg::*;
#(
  parameter int RESET_WAIT = 1,
  parameter int PERF_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  ifetch_if.ifm             bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  localparam int CNT_W = (RESET_WAIT < 2) ? 1 : $clog2(RESET_WAIT + 1);

  if (PERF_W < 1 || RESET_WAIT < 1) begin : g_bad_params
    $error("ifetch_unit: PERF_W and RESET_WAIT must both be at least 1");
  end

  ifetch_state_t    state_q, state_d;
  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  ifid_t fetched;
  ifid_t hb_q;
  logic  hb_load, hb_drain, hb_clr;
  logic  pc_en;
  logic  boot_done;
  logic  redirect_take;
  logic  halt_take;

  assign fetched       = '{valid: 1'b1, instr: bus.iload, pc: bus.pc, npc: bus.npc};
  assign boot_done     = (int'(rst_cnt_q) + 1) >= RESET_WAIT;
  // Halt outranks redirect; neither is honoured once halted.
  assign halt_take     = bus.halt && (state_q != HALTED);
  assign redirect_take = bus.redirect && !bus.halt &&
                         ((state_q == FETCH) || (state_q == HOLD));

  always_comb begin
    state_d   = state_q;
    ifid_d    = ifid_q;
    rst_cnt_d = rst_cnt_q;
    pc_en     = 1'b0;
    hb_load   = 1'b0;
    hb_drain  = 1'b0;
    hb_clr    = 1'b0;

    case (state_q)
      RESET: begin
        if (boot_done) state_d = FETCH;
        else           rst_cnt_d = rst_cnt_q + CNT_W'(1);
      end
      FETCH: begin
        if (bus.ihit) begin
          pc_en = 1'b1;
          if (!bus.dstall) begin
            ifid_d = fetched;
          end else begin
            hb_load = 1'b1;
            state_d = HOLD;
          end
        end else if (!bus.dstall) begin
          ifid_d.valid = 1'b0;
        end
      end
      HOLD: begin
        if (!bus.dstall) begin
          ifid_d   = hb_q;
          hb_drain = 1'b1;
          state_d  = FETCH;
        end
      end
      HALTED: begin
        ifid_d.valid = 1'b0;
      end
      default: state_d = RESET;
    endcase

    // Squash keeps the old IF/ID payload; only its valid bit is dropped.
    if (redirect_take) begin
      pc_en        = 1'b1;
      ifid_d       = ifid_q;
      ifid_d.valid = 1'b0;
      hb_clr       = 1'b1;
      state_d      = FETCH;
    end

    if (halt_take) begin
      pc_en        = 1'b0;
      ifid_d       = ifid_q;
      ifid_d.valid = 1'b0;
      hb_clr       = 1'b1;
      state_d      = HALTED;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RESET;
      ifid_q    <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ifid_q    <= ifid_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  ifetch_hold_buf u_hold_buf (
    .clk   (CLK),
    .rst_n (nRST),
    .load  (hb_load),
    .drain (hb_drain),
    .clr   (hb_clr),
    .d     (fetched),
    .q     (hb_q)
  );

  assign bus.PCen       = pc_en;
  assign bus.cpc        = redirect_take ? bus.redirect_pc : bus.npc;
  assign bus.iREN       = (state_q == FETCH);
  assign bus.iaddr      = bus.pc;
  assign bus.ifid_valid = ifid_q.valid;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_pc    = ifid_q.pc;
  assign bus.ifid_npc   = ifid_q.npc;
  assign bus.state      = state_q;

`ifdef IFETCH_PERF_EN
  logic              ev_fetch, ev_stall, ev_flush;
  logic [PERF_W-1:0] perf_fetch_q, perf_fetch_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

  assign ev_fetch = (state_q == FETCH) && bus.ihit && !redirect_take && !halt_take;
  assign ev_stall = (state_q == HOLD) || ((state_q == FETCH) && !bus.ihit);
  assign ev_flush = redirect_take &&
                    (ifid_q.valid || hb_q.valid || ((state_q == FETCH) && bus.ihit));

  always_comb begin
    perf_fetch_d = sat_inc(perf_fetch_q, ev_fetch);
    perf_stall_d = sat_inc(perf_stall_q, ev_stall);
    perf_flush_d = sat_inc(perf_flush_q, ev_flush);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// against a transaction-level reference model (covers IFETCH_PERF_EN when defined).
module tb_ifetch_unit;
  import cpu_types_pkg::*;

  localparam int RESET_WAIT = 1;
  localparam int PERF_W     = 32;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  ifetch_if bus ();

`ifdef IFETCH_PERF_EN
  logic [PERF_W-1:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  ifetch_unit #(.RESET_WAIT(RESET_WAIT), .PERF_W(PERF_W)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .bus            (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_q[$];
  ifetch_state_t m_state;
  bit            m_valid, m_hvalid;
  word_t         m_instr, m_pc, m_npc, m_hinstr, m_hpc, m_hnpc;
  int            m_boot, m_fetch, m_stall, m_flush;
  bit            exp_pcen, exp_iren;
  word_t         exp_cpc;

  task automatic model_reset();
    m_state = RESET;
    m_valid = 0; m_hvalid = 0;
    m_instr = '0; m_pc = '0; m_npc = '0;
    m_boot = 0; m_fetch = 0; m_stall = 0; m_flush = 0;
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.ihit = 0; bus.iload = '0; bus.dstall = 0;
    bus.redirect = 0; bus.redirect_pc = '0; bus.halt = 0;
  endtask

  task automatic set_pc(input word_t p);
    bus.pc = p; bus.npc = p + 32'd4;
  endtask

  // One clock: check DUT against the model mid-cycle, advance the model, cross the edge.
  task automatic step();
    bit rd, hl;
    logic [31:0] front;
    #1;
    hl = bus.halt && (m_state != HALTED);
    rd = bus.redirect && !bus.halt && (m_state == FETCH || m_state == HOLD);
    exp_iren = (m_state == FETCH);
    exp_pcen = !hl && (rd || (m_state == FETCH && bus.ihit));
    exp_cpc  = rd ? bus.redirect_pc : bus.npc;

    n_cmp++;
    if ({bus.PCen, bus.iREN, bus.ifid_valid} !== {exp_pcen, exp_iren, m_valid}) begin
      n_bad++;
      $display("FAIL ctl t=%0t {PCen,iREN,valid} got=%b exp=%b", $time,
               {bus.PCen, bus.iREN, bus.ifid_valid}, {exp_pcen, exp_iren, m_valid});
    end
    n_cmp++;
    if (bus.state !== m_state) begin
      n_bad++; $display("FAIL state t=%0t got=%0d exp=%0d", $time, bus.state, m_state);
    end
    n_cmp++;
    if ({bus.cpc, bus.iaddr} !== {exp_cpc, bus.pc}) begin
      n_bad++;
      $display("FAIL cpc_iaddr t=%0t got=%h/%h exp=%h/%h", $time, bus.cpc, bus.iaddr, exp_cpc, bus.pc);
    end
    if (m_valid) begin
      n_cmp++;
      if ({bus.ifid_instr, bus.ifid_pc, bus.ifid_npc} !== {m_instr, m_pc, m_npc}) begin
        n_bad++;
        $display("FAIL ifid t=%0t got=%h/%h/%h exp=%h/%h/%h", $time, bus.ifid_instr,
                 bus.ifid_pc, bus.ifid_npc, m_instr, m_pc, m_npc);
      end
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !==
        {PERF_W'(m_fetch), PERF_W'(m_stall), PERF_W'(m_flush)}) begin
      n_bad++;
      $display("FAIL perf t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time, perf_fetch_cnt,
               perf_stall_cnt, perf_flush_cnt, m_fetch, m_stall, m_flush);
    end
`endif

    // Decode consumes the IF/ID entry at this edge: it must be the oldest accepted word.
    if (!hl && !rd && m_valid && !bus.dstall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL sb_order t=%0t got=%h exp=<empty>", $time, bus.ifid_instr);
      end else begin
        front = exp_q.pop_front();
        if (bus.ifid_instr !== front) begin
          n_bad++; $display("FAIL sb_order t=%0t got=%h exp=%h", $time, bus.ifid_instr, front);
        end
      end
    end

    if (m_state == HOLD || (m_state == FETCH && !bus.ihit)) m_stall++;
    if (hl) begin
      m_state = HALTED; m_valid = 0; m_hvalid = 0; exp_q.delete();
    end else if (rd) begin
      if (m_valid || m_hvalid || (m_state == FETCH && bus.ihit)) m_flush++;
      m_state = FETCH; m_valid = 0; m_hvalid = 0; exp_q.delete();
    end else begin
      case (m_state)
        RESET: begin
          m_boot++;
          if (m_boot >= RESET_WAIT) m_state = FETCH;
        end
        FETCH: begin
          if (bus.ihit) begin
            m_fetch++;
            exp_q.push_back(bus.iload);
            if (!bus.dstall) begin
              m_valid = 1; m_instr = bus.iload; m_pc = bus.pc; m_npc = bus.npc;
            end else begin
              m_hvalid = 1; m_hinstr = bus.iload; m_hpc = bus.pc; m_hnpc = bus.npc;
              m_state = HOLD;
            end
          end else if (!bus.dstall) begin
            m_valid = 0;
          end
        end
        HOLD: begin
          if (!bus.dstall) begin
            m_valid = m_hvalid; m_instr = m_hinstr; m_pc = m_hpc; m_npc = m_hnpc;
            m_hvalid = 0; m_state = FETCH;
          end
        end
        default: m_valid = 0;
      endcase
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 0;
    drive_idle();
    set_pc(32'h0);
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if ({bus.PCen, bus.iREN, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_npc} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got PCen=%b iREN=%b v=%b %h/%h/%h exp=all zero", bus.PCen,
               bus.iREN, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_npc);
    end
    n_cmp++;
    if (bus.state !== RESET) begin
      n_bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, RESET);
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0",
                        perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
    end
`endif
    @(negedge CLK);
    nRST = 1;
    step();
  endtask

  task automatic test_basic_fetch();
    set_pc(32'h0);
    step();
    step();
    bus.ihit = 1; bus.iload = 32'h2001_0005;
    #1;
    n_cmp++;
    if ({bus.PCen, bus.cpc} !== {1'b1, 32'h4}) begin
      n_bad++; $display("FAIL basic_pcen got PCen=%b cpc=%h exp PCen=1 cpc=00000004", bus.PCen, bus.cpc);
    end
    step();
    n_cmp++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc} !== {1'b1, 32'h2001_0005, 32'h0}) begin
      n_bad++; $display("FAIL basic_ifid got v=%b %h pc=%h exp v=1 20010005 pc=00000000",
                        bus.ifid_valid, bus.ifid_instr, bus.ifid_pc);
    end
    drive_idle();
    set_pc(32'h4);
    step();
  endtask

  task automatic test_hold();
    set_pc(32'hC); bus.ihit = 1; bus.iload = 32'h1111_0000;
    step();
    set_pc(32'h10); bus.iload = 32'h8C22_0000; bus.dstall = 1;
    #1;
    n_cmp++;
    if (bus.PCen !== 1'b1) begin
      n_bad++; $display("FAIL hold_pcen got=%b exp=1", bus.PCen);
    end
    step();
    set_pc(32'h14); bus.iload = 32'hBAD0_0BAD;  // ihit while iREN=0 must be ignored
    n_cmp++;
    if ({bus.ifid_instr, bus.ifid_pc, bus.iREN, bus.state} !== {32'h1111_0000, 32'hC, 1'b0, HOLD}) begin
      n_bad++; $display("FAIL hold_unchanged got %h pc=%h iREN=%b st=%0d exp 11110000 pc=0000000c iREN=0 st=%0d",
                        bus.ifid_instr, bus.ifid_pc, bus.iREN, bus.state, HOLD);
    end
    step();
    bus.ihit = 0; bus.dstall = 0;
    step();
    n_cmp++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.state} !== {1'b1, 32'h8C22_0000, 32'h10, FETCH}) begin
      n_bad++; $display("FAIL hold_drain got v=%b %h pc=%h st=%0d exp v=1 8c220000 pc=00000010 st=%0d",
                        bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.state, FETCH);
    end
  endtask

  task automatic test_redirect_ihit();
    bus.dstall = 1; bus.ihit = 1; bus.iload = 32'hDEAD_BEEF;
    bus.redirect = 1; bus.redirect_pc = 32'h40;
    #1;
    n_cmp++;
    if ({bus.PCen, bus.cpc} !== {1'b1, 32'h40}) begin
      n_bad++; $display("FAIL redir_cpc got PCen=%b cpc=%h exp PCen=1 cpc=00000040", bus.PCen, bus.cpc);
    end
    step();
    drive_idle();
    set_pc(32'h40);
    #1;
    n_cmp++;
    if ({bus.ifid_valid, bus.iaddr, bus.state} !== {1'b0, 32'h40, FETCH}) begin
      n_bad++; $display("FAIL redir_after got v=%b iaddr=%h st=%0d exp v=0 iaddr=00000040 st=%0d",
                        bus.ifid_valid, bus.iaddr, bus.state, FETCH);
    end
    step();
  endtask

  task automatic test_redirect_hold();
    bus.ihit = 1; bus.iload = 32'h0123_4567; bus.dstall = 1;
    step();
    bus.ihit = 0; bus.redirect = 1; bus.redirect_pc = 32'h80;
    step();
    n_cmp++;
    if ({bus.ifid_valid, bus.state} !== {1'b0, FETCH}) begin
      n_bad++; $display("FAIL redir_hold got v=%b st=%0d exp v=0 st=%0d", bus.ifid_valid, bus.state, FETCH);
    end
    drive_idle();
    set_pc(32'h80);
    step();
    step();
  endtask

  task automatic test_random();
    word_t cur_pc;
    cur_pc = bus.pc;
    for (int i = 0; i < 600; i++) begin
      set_pc(cur_pc);
      bus.ihit        = ($urandom_range(0, 1) == 1);
      bus.iload       = $urandom;
      bus.dstall      = ($urandom_range(0, 3) == 0);
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
      bus.halt        = 0;
      step();
      if (exp_pcen) cur_pc = exp_cpc;
    end
    drive_idle();
  endtask

  task automatic test_halt();
    bus.ihit = 1; bus.iload = 32'h5555_AAAA;
    step();
    bus.halt = 1;
    step();
    for (int i = 0; i < 12; i++) begin
      bus.halt        = ($urandom_range(0, 1) == 1);
      bus.ihit        = ($urandom_range(0, 1) == 1);
      bus.dstall      = ($urandom_range(0, 1) == 1);
      bus.redirect    = ($urandom_range(0, 1) == 1);
      bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
      step();
    end
    test_reset();
  endtask

  task automatic test_reset_midfetch();
    set_pc(32'h100); bus.ihit = 1; bus.iload = 32'h7777_0001;
    #2;
    nRST = 0;
    #1;
    n_cmp++;
    if ({bus.PCen, bus.iREN, bus.state} !== {1'b0, 1'b0, RESET}) begin
      n_bad++; $display("FAIL midfetch_reset got PCen=%b iREN=%b st=%0d exp 0 0 %0d",
                        bus.PCen, bus.iREN, bus.state, RESET);
    end
    @(negedge CLK);
    nRST = 1;
    drive_idle();
    model_reset();
    step();
    step();
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    test_reset();
    set_pc(32'h200);
    step();                                                      // stall 1
    bus.ihit = 1; bus.iload = 32'hA; step();                     // fetch 1
    bus.iload = 32'hB; bus.dstall = 1; step();                   // fetch 2 -> HOLD
    bus.ihit = 0; step(); step();                                // stall 2, 3
    bus.dstall = 0; step();                                      // stall 4, drain
    bus.ihit = 1; bus.iload = 32'hC; step();                     // fetch 3
    bus.redirect = 1; bus.redirect_pc = 32'h300; step();         // flush 1
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {PERF_W'(3), PERF_W'(4), PERF_W'(1)}) begin
      n_bad++; $display("FAIL perf_plan got=%0d/%0d/%0d exp=3/4/1",
                        perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
    end
    drive_idle();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_fetch();
    test_hold();
    test_redirect_ihit();
    test_redirect_hold();
    test_random();
    test_halt();
    test_reset_midfetch();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
